// File: rtl/hazard_control_unit_if.sv
// Pipeline <-> hazard controller bundle: hazard inputs from the pipeline latches
// and the per-latch enable/flush controls driven back by the controller.
interface hazard_control_unit_if #(
  parameter int REG_W = 5
);
  logic             ihit;
  logic             dhit;
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic             ifid_rt_used;
  logic [REG_W-1:0] idex_wsel;
  logic             idex_regWr;
  logic             idex_dmemren;
  logic             exmem_dmemren;
  logic             exmem_dmemwen;
  logic             exmem_redirect;
  logic             exmem_halt;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             halted;

  modport master (
    output ihit, dhit, ifid_rs, ifid_rt, ifid_rt_used, idex_wsel, idex_regWr,
           idex_dmemren, exmem_dmemren, exmem_dmemwen, exmem_redirect, exmem_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halted
  );

  modport slave (
    input  ihit, dhit, ifid_rs, ifid_rt, ifid_rt_used, idex_wsel, idex_regWr,
           idex_dmemren, exmem_dmemren, exmem_dmemwen, exmem_redirect, exmem_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halted
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage core: load-use, I/D-miss, MEM redirect and halt.
// Optional HAZARD_PERF_EN adds saturating stall_cycles / flush_events counters.
module hazard_control_unit #(
  parameter int REG_W = 5
`ifdef HAZARD_PERF_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic                 CLK,
  input  logic                 RST,
  hazard_control_unit_if.slave hif
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]    stall_cycles,
  output logic [PERF_W-1:0]    flush_events
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    RWAIT = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e state_q;
  state_e state_d;

  logic dmem_busy_s;
  logic lu_s;
  logic run_eval_s;
  logic pc_en_s;
  logic ifid_en_s;
  logic idex_en_s;
  logic exmem_en_s;
  logic memwb_en_s;
  logic ifid_flush_s;
  logic idex_flush_s;
  logic exmem_flush_s;
  logic memwb_flush_s;
  logic halted_s;

  assign dmem_busy_s = (hif.exmem_dmemren | hif.exmem_dmemwen) & ~hif.dhit;
  assign lu_s = hif.idex_dmemren & hif.idex_regWr & (hif.idex_wsel != {REG_W{1'b0}}) &
                ((hif.ifid_rs == hif.idex_wsel) |
                 (hif.ifid_rt_used & (hif.ifid_rt == hif.idex_wsel)));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and latch control; DWAIT-with-dhit is resolved exactly like RUN
  always_comb begin
    state_d       = state_q;
    run_eval_s    = 1'b0;
    pc_en_s       = hif.ihit;
    ifid_en_s     = 1'b1;
    idex_en_s     = 1'b1;
    exmem_en_s    = 1'b1;
    memwb_en_s    = 1'b1;
    ifid_flush_s  = ~hif.ihit;
    idex_flush_s  = 1'b0;
    exmem_flush_s = 1'b0;
    memwb_flush_s = 1'b0;
    halted_s      = 1'b0;
    if (RST) begin
      state_d       = RUN;
      pc_en_s       = 1'b0;
      ifid_en_s     = 1'b0;
      idex_en_s     = 1'b0;
      exmem_en_s    = 1'b0;
      memwb_en_s    = 1'b0;
      ifid_flush_s  = 1'b1;
      idex_flush_s  = 1'b1;
      exmem_flush_s = 1'b1;
      memwb_flush_s = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          run_eval_s = 1'b1;
        end
        DWAIT: begin
          if (hif.dhit) begin
            state_d    = RUN;
            run_eval_s = 1'b1;
          end else begin
            pc_en_s       = 1'b0;
            ifid_en_s     = 1'b0;
            idex_en_s     = 1'b0;
            exmem_en_s    = 1'b0;
            ifid_flush_s  = 1'b0;
            memwb_flush_s = 1'b1;
          end
        end
        RWAIT: begin
          if (hif.ihit) begin
            state_d       = RUN;
            pc_en_s       = 1'b1;
            ifid_flush_s  = 1'b1;
            idex_flush_s  = 1'b1;
            exmem_flush_s = 1'b1;
          end else begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            idex_en_s    = 1'b0;
            exmem_en_s   = 1'b0;
            memwb_en_s   = 1'b0;
            ifid_flush_s = 1'b0;
          end
        end
        HALT: begin
          pc_en_s      = 1'b0;
          ifid_en_s    = 1'b0;
          idex_en_s    = 1'b0;
          exmem_en_s   = 1'b0;
          ifid_flush_s = 1'b0;
          halted_s     = 1'b1;
        end
        default: begin
          state_d = RUN;
        end
      endcase

      if (run_eval_s) begin
        if (hif.exmem_halt) begin
          state_d = HALT;
        end else if (dmem_busy_s) begin
          // Freeze the front of the pipe; WB gets a bubble while MEM waits
          state_d       = DWAIT;
          pc_en_s       = 1'b0;
          ifid_en_s     = 1'b0;
          idex_en_s     = 1'b0;
          exmem_en_s    = 1'b0;
          ifid_flush_s  = 1'b0;
          memwb_flush_s = 1'b1;
        end else if (hif.exmem_redirect & hif.ihit) begin
          pc_en_s       = 1'b1;
          ifid_flush_s  = 1'b1;
          idex_flush_s  = 1'b1;
          exmem_flush_s = 1'b1;
        end else if (hif.exmem_redirect) begin
          state_d      = RWAIT;
          pc_en_s      = 1'b0;
          ifid_en_s    = 1'b0;
          idex_en_s    = 1'b0;
          exmem_en_s   = 1'b0;
          memwb_en_s   = 1'b0;
          ifid_flush_s = 1'b0;
        end else if (lu_s) begin
          pc_en_s      = 1'b0;
          ifid_en_s    = 1'b0;
          ifid_flush_s = 1'b0;
          idex_flush_s = 1'b1;
        end else begin
          state_d = state_d;
        end
      end else begin
        state_d = state_d;
      end
    end
  end

  assign hif.pc_en       = pc_en_s;
  assign hif.ifid_en     = ifid_en_s;
  assign hif.idex_en     = idex_en_s;
  assign hif.exmem_en    = exmem_en_s;
  assign hif.memwb_en    = memwb_en_s;
  assign hif.ifid_flush  = ifid_flush_s;
  assign hif.idex_flush  = idex_flush_s;
  assign hif.exmem_flush = exmem_flush_s;
  assign hif.memwb_flush = memwb_flush_s;
  assign hif.halted      = halted_s;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] flush_q;
  logic              stall_inc_s;

  assign stall_inc_s = ~pc_en_s & (state_q != HALT);

  // Saturating event counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= {PERF_W{1'b0}};
      flush_q <= {PERF_W{1'b0}};
    end else begin
      if (stall_inc_s && (stall_q != {PERF_W{1'b1}})) begin
        stall_q <= stall_q + {{(PERF_W-1){1'b0}}, 1'b1};
      end else begin
        stall_q <= stall_q;
      end
      if (exmem_flush_s && (flush_q != {PERF_W{1'b1}})) begin
        flush_q <= flush_q + {{(PERF_W-1){1'b0}}, 1'b1};
      end else begin
        flush_q <= flush_q;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: stimulus pushes expected controls, negedge monitor compares.
module tb_hazard_control_unit;

  logic CLK;
  logic RST;
  hazard_control_unit_if #(.REG_W(5)) hif ();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
`endif

  hazard_control_unit #(.REG_W(5)) dut (
    .CLK(CLK),
    .RST(RST),
    .hif(hif)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bit order: pc_en ifid_en idex_en exmem_en memwb_en | ifid_fl idex_fl exmem_fl memwb_fl | halted
  localparam logic [9:0] E_RESET = 10'b0_0000_1111_0;
  localparam logic [9:0] E_DEF   = 10'b1_1111_0000_0;
  localparam logic [9:0] E_NOIH  = 10'b0_1111_1000_0;
  localparam logic [9:0] E_LU    = 10'b0_0111_0100_0;
  localparam logic [9:0] E_FRZ   = 10'b0_0001_0001_0;
  localparam logic [9:0] E_RSTL  = 10'b0_0000_0000_0;
  localparam logic [9:0] E_REDIR = 10'b1_1111_1110_0;
  localparam logic [9:0] E_HALT  = 10'b0_0001_0000_1;
  localparam logic [9:0] M_ALL   = 10'b1_1111_1111_1;
  localparam logic [9:0] M_FRZ   = 10'b1_1111_0001_1;
  localparam logic [9:0] M_ENH   = 10'b1_1111_0000_1;

  typedef struct {
    string       name;
    logic [9:0]  exp;
    logic [9:0]  mask;
    bit          chk_perf;
    logic [31:0] st;
    logic [31:0] fl;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [9:0] act;
  int n_cmp = 0;
  int n_err = 0;

  // Monitor: pops one expectation per cycle, samples on the falling edge
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
             hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.memwb_flush, hif.halted};
      n_cmp++;
      if ((act & e.mask) !== (e.exp & e.mask)) begin
        n_err++;
        $display("FAIL %s: got %b want %b (mask %b)", e.name, act, e.exp, e.mask);
      end
`ifdef HAZARD_PERF_EN
      if (e.chk_perf) begin
        n_cmp++;
        if (stall_cycles !== e.st || flush_events !== e.fl) begin
          n_err++;
          $display("FAIL %s_perf: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                   e.name, stall_cycles, flush_events, e.st, e.fl);
        end
      end
`endif
    end
  end

  task automatic clr(input logic rst, input logic ih);
    RST                = rst;
    hif.ihit           = ih;
    hif.dhit           = 1'b0;
    hif.ifid_rs        = 5'd0;
    hif.ifid_rt        = 5'd0;
    hif.ifid_rt_used   = 1'b0;
    hif.idex_wsel      = 5'd0;
    hif.idex_regWr     = 1'b0;
    hif.idex_dmemren   = 1'b0;
    hif.exmem_dmemren  = 1'b0;
    hif.exmem_dmemwen  = 1'b0;
    hif.exmem_redirect = 1'b0;
    hif.exmem_halt     = 1'b0;
  endtask

  task automatic chkp(input string nm, input logic [9:0] ex, input logic [9:0] mk,
                      input bit cp, input logic [31:0] st, input logic [31:0] fl);
    exp_t t;
    t.name = nm; t.exp = ex; t.mask = mk; t.chk_perf = cp; t.st = st; t.fl = fl;
    sb.push_back(t);
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [9:0] ex, input logic [9:0] mk);
    chkp(nm, ex, mk, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic set_lu(input logic [4:0] wsel, input logic [4:0] rs,
                        input logic [4:0] rt, input logic rt_used);
    hif.idex_dmemren = 1'b1;
    hif.idex_regWr   = 1'b1;
    hif.idex_wsel    = wsel;
    hif.ifid_rs      = rs;
    hif.ifid_rt      = rt;
    hif.ifid_rt_used = rt_used;
  endtask

  initial begin
    clr(1'b1, 1'b0);
    @(posedge CLK);
    #1;
    // Reset
    clr(1'b1, 1'b0); chk("reset0", E_RESET, M_ALL);
    clr(1'b1, 1'b1); chk("reset1", E_RESET, M_ALL);
    clr(1'b0, 1'b1); chk("post_reset", E_DEF, M_ALL);
    clr(1'b0, 1'b0); chk("imiss_bubble", E_NOIH, M_ALL);
    // Load-use via rs, then NOP in EX
    clr(1'b0, 1'b1); set_lu(5'd5, 5'd5, 5'd0, 1'b0); chk("lu_rs", E_LU, M_ALL);
    clr(1'b0, 1'b1); hif.ifid_rs = 5'd5; chk("lu_rs_after", E_DEF, M_ALL);
    // Load-use via rt
    clr(1'b0, 1'b1); set_lu(5'd7, 5'd3, 5'd7, 1'b1); chk("lu_rt", E_LU, M_ALL);
    clr(1'b0, 1'b1); chk("lu_rt_after", E_DEF, M_ALL);
    clr(1'b0, 1'b1); set_lu(5'd7, 5'd3, 5'd7, 1'b0); chk("lu_rt_unused", E_DEF, M_ALL);
    clr(1'b0, 1'b1); set_lu(5'd0, 5'd0, 5'd0, 1'b1); chk("lu_wsel0", E_DEF, M_ALL);
    clr(1'b0, 1'b1); set_lu(5'd9, 5'd9, 5'd0, 1'b0); hif.idex_regWr = 1'b0;
    chk("lu_nowr", E_DEF, M_ALL);
    // Fresh reset so perf counters count only the D-miss and redirect scenarios
    clr(1'b1, 1'b1); chk("reset2", E_RESET, M_ALL);
    clr(1'b1, 1'b1); chk("reset3", E_RESET, M_ALL);
    clr(1'b0, 1'b1); chk("post_reset2", E_DEF, M_ALL);
    // D-miss: three cycles of freeze, then dhit
    for (int i = 0; i < 3; i++) begin
      clr(1'b0, 1'b1); hif.exmem_dmemren = 1'b1; chk($sformatf("dmiss%0d", i), E_FRZ, M_FRZ);
    end
    clr(1'b0, 1'b1); hif.exmem_dmemren = 1'b1; hif.dhit = 1'b1; chk("dmiss_hit", E_DEF, M_ALL);
    clr(1'b0, 1'b1); chk("dmiss_run", E_DEF, M_ALL);
    // Redirect with I-miss
    clr(1'b0, 1'b0); hif.exmem_redirect = 1'b1; chk("redir_miss0", E_RSTL, M_ENH);
    clr(1'b0, 1'b0); hif.exmem_redirect = 1'b1; chk("redir_miss1", E_RSTL, M_ENH);
    clr(1'b0, 1'b1); hif.exmem_redirect = 1'b1; chk("redir_fill", E_REDIR, M_ALL);
    clr(1'b0, 1'b1); chkp("redir_done", E_DEF, M_ALL, 1'b1, 32'd5, 32'd1);
    // Redirect and load-use together: redirect wins
    clr(1'b0, 1'b1); set_lu(5'd4, 5'd4, 5'd0, 1'b0); hif.exmem_redirect = 1'b1;
    chk("redir_lu", E_REDIR, M_ALL);
    clr(1'b0, 1'b1); chk("redir_lu_after", E_DEF, M_ALL);
    // Store miss then reset mid-DWAIT
    clr(1'b0, 1'b1); hif.exmem_dmemwen = 1'b1; chk("st_miss", E_FRZ, M_FRZ);
    clr(1'b1, 1'b1); hif.exmem_dmemwen = 1'b1; chk("rst_in_dwait", E_RESET, M_ALL);
    clr(1'b0, 1'b1); chk("after_rst_dwait", E_DEF, M_ALL);
    // Halt: holds until reset
    clr(1'b0, 1'b1); hif.exmem_halt = 1'b1; chk("halt_enter", E_DEF, M_ALL);
    for (int i = 0; i < 12; i++) begin
      clr(1'b0, i[0]); hif.exmem_redirect = i[1]; chk($sformatf("halt%0d", i), E_HALT, M_ENH);
    end
    clr(1'b1, 1'b1); chk("halt_rst", E_RESET, M_ALL);
    clr(1'b0, 1'b1); chk("halt_cleared", E_DEF, M_ALL);
    // Drain with a bounded wait
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge CLK);
    #1;
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
